// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants, FSM state enum and operand pair type for mac_sched
package mac_pkg;

  localparam int WORD_SIZE = 8;
  localparam int BREADTH   = 4;
  localparam int ADDR_W    = 8;
  localparam int BUS_WIDTH = 2 * WORD_SIZE;
  // one extra bit so the index can count past BREADTH-1 without aliasing, also for BREADTH=1
  localparam int IDX_W     = $clog2(BREADTH) + 1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    DRAIN,
    CAPTURE,
    RESP
  } sched_state_t;

  typedef struct packed {
    logic [WORD_SIZE-1:0] wt;
    logic [WORD_SIZE-1:0] x;
  } pair_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic found;
  int   cand;

  // scan N candidates starting at ptr, wrapping, and keep the first one asserted
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/mac_sched.sv
// rtl/mac_sched.sv - round-robin job sequencer sharing one MAC; optional counters under MAC_SCHED_PERF_EN
module mac_sched
  import mac_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_base,
  output logic [NUM_REQ-1:0]        done,
  output logic [WORD_SIZE-1:0]      result,
  output logic                      busy,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [BUS_WIDTH-1:0]      rd_data,
  output logic                      mac_clr,
  output logic                      mac_en,
  output logic [BUS_WIDTH-1:0]      bus,
  input  logic [WORD_SIZE-1:0]      mac_result
`ifdef MAC_SCHED_PERF_EN
  ,
  output logic [31:0]               perf_jobs,
  output logic [31:0]               perf_busy
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  sched_state_t state, state_nxt;

  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      id_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [ADDR_W-1:0]    base_q;
  logic [IDX_W-1:0]     idx;
  logic                 beat_q;
  logic [WORD_SIZE-1:0] result_q;

  logic [NUM_REQ-1:0]   grant;
  logic [ID_W-1:0]      grant_idx;
  logic                 any_req;
  pair_t                beat_pair;

  assign any_req   = |req;
  assign beat_pair = rd_data;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state: requests only matter in IDLE; the rest of the job is a fixed walk
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = CLEAR;
      CLEAR:   state_nxt = ISSUE;
      ISSUE:   if (idx == IDX_W'(BREADTH - 1)) state_nxt = DRAIN;
      DRAIN:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: reads come from ISSUE, MAC beats trail them by one cycle via beat_q
  always_comb begin
    mac_clr = (state == CLEAR);
    rd_en   = (state == ISSUE);
    rd_addr = '0;
    if (state == ISSUE) rd_addr = base_q + ADDR_W'(idx);
    busy    = (state != IDLE);
    mac_en  = beat_q;
    bus     = beat_q ? beat_pair : '0;
    done    = (state == RESP) ? grant_q : '0;
    result  = (state == RESP) ? result_q : '0;
  end

  // job context: latch the winner, step the operand index, capture the MAC, advance the pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      id_q     <= '0;
      grant_q  <= '0;
      base_q   <= '0;
      idx      <= '0;
      beat_q   <= 1'b0;
      result_q <= '0;
    end else begin
      beat_q <= (state == ISSUE);
      case (state)
        IDLE: begin
          if (any_req) begin
            id_q    <= grant_idx;
            grant_q <= grant;
            base_q  <= req_base[int'(grant_idx)*ADDR_W +: ADDR_W];
          end
        end
        CLEAR:   idx <= '0;
        ISSUE:   idx <= idx + IDX_W'(1);
        CAPTURE: result_q <= mac_result;
        RESP:    ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
        default: ;
      endcase
    end
  end

`ifdef MAC_SCHED_PERF_EN
  // saturating counters of completed jobs and busy cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_jobs <= '0;
      perf_busy <= '0;
    end else begin
      if (state == RESP && perf_jobs != '1) perf_jobs <= perf_jobs + 32'd1;
      if (busy && perf_busy != '1)          perf_busy <= perf_busy + 32'd1;
    end
  end
`endif

endmodule
